exc_ctrl: RTL and testbench

- Exception/interrupt controller that sequences the CP0 register file.
- Samples the MEM-stage instruction's exception flags, prioritises them, and drives CP0's excepttype/EPC-update inputs as a one-cycle pulse.
- Synchronises external interrupt lines and flushes the pipeline.
- Waits for any outstanding data-bus transaction, then hands the fetch stage a redirect PC (exception vector, or EPC for ERET) through a valid/ready handshake.

---
 rtl/exc_ctrl.sv | 155 +++++++++++++++
 tb/tb_exc_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: prioritises MEM-stage exceptions, pulses CP0, flushes and redirects fetch.
// Optional timer interrupt input enabled by defining EXC_CTRL_TIMER_INT_EN.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
`ifdef EXC_CTRL_TIMER_INT_EN
    input  logic        timer_int_i,
`endif
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [7:0]  mem_exc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_busy_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  int_sync_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, REDIRECT} state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [6*SYNC_STAGES-1:0]    r_sync;
    logic [5:0]                  w_sync_raw;
    logic                        w_pend;
    logic                        w_det;
    logic                        w_capture;
    logic                        w_flush;
    logic [31:0]                 w_code;
    logic [31:0]                 w_bad;
    logic [31:0]                 r_excepttype;
    logic [31:0]                 r_pc;
    logic                        r_ds;
    logic [31:0]                 r_bad;
    logic [31:0]                 r_target;

    // Synchroniser as a packed shift chain, newest sample in the low 6 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[6*SYNC_STAGES-7:0], int_i};
        end
    end

    assign w_sync_raw = r_sync[6*SYNC_STAGES-1 -: 6];

`ifdef EXC_CTRL_TIMER_INT_EN
    assign int_sync_o = w_sync_raw | {timer_int_i, 5'b0};
`else
    assign int_sync_o = w_sync_raw;
`endif

    assign w_pend = (|({int_sync_o, cause_i[9:8]} & status_i[15:8])) && status_i[0] && !status_i[1];
    assign w_det  = mem_valid_i && (w_pend || (|mem_exc_i));

    always_comb begin
        w_code = '0;
        w_bad  = '0;
        if (w_pend) begin
            w_code = 32'h1;
        end else if (mem_exc_i[0]) begin
            w_code = 32'h4;
            w_bad  = mem_pc_i;
        end else if (mem_exc_i[1]) begin
            w_code = 32'ha;
        end else if (mem_exc_i[2]) begin
            w_code = 32'hc;
        end else if (mem_exc_i[3]) begin
            w_code = 32'h8;
        end else if (mem_exc_i[4]) begin
            w_code = 32'h9;
        end else if (mem_exc_i[5]) begin
            w_code = 32'he;
        end else if (mem_exc_i[6]) begin
            w_code = 32'h4;
            w_bad  = mem_addr_i;
        end else if (mem_exc_i[7]) begin
            w_code = 32'h5;
            w_bad  = mem_addr_i;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_flush   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_det) begin
                    w_flush   = 1'b1;
                    w_capture = 1'b1;
                    w_next    = mem_busy_i ? WAIT_MEM : REDIRECT;
                end
            end
            WAIT_MEM: begin
                w_flush = 1'b1;
                if (!mem_busy_i) w_next = REDIRECT;
            end
            REDIRECT: begin
                w_flush = 1'b1;
                if (redirect_ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // CP0 fields are a single-cycle pulse; the redirect target persists until the next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_excepttype <= '0;
            r_pc         <= '0;
            r_ds         <= 1'b0;
            r_bad        <= '0;
            r_target     <= '0;
        end else begin
            r_excepttype <= w_capture ? w_code : '0;
            r_pc         <= w_capture ? mem_pc_i : '0;
            r_ds         <= w_capture & mem_in_delayslot_i;
            r_bad        <= w_capture ? w_bad : '0;
            if (w_capture) r_target <= (w_code == 32'he) ? epc_i : EXC_VECTOR;
        end
    end

    assign excepttype_o        = r_excepttype;
    assign current_inst_addr_o = r_pc;
    assign is_in_delayslot_o   = r_ds;
    assign bad_addr_o          = r_bad;
    assign flush_o             = w_flush;
    assign redirect_valid_o    = (r_state == REDIRECT);
    assign redirect_pc_o       = redirect_valid_o ? r_target : '0;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC00380;
    localparam int          SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  int_i = '0;
`ifdef EXC_CTRL_TIMER_INT_EN
    logic        timer_int_i = 1'b0;
`endif
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_pc_i = '0;
    logic        mem_in_delayslot_i = 1'b0;
    logic [7:0]  mem_exc_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic        mem_busy_i = 1'b0;
    logic [31:0] status_i = '0;
    logic [31:0] cause_i = '0;
    logic [31:0] epc_i = '0;
    logic        redirect_ready_i = 1'b0;
    logic [5:0]  int_sync_o;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .int_i               (int_i),
`ifdef EXC_CTRL_TIMER_INT_EN
        .timer_int_i         (timer_int_i),
`endif
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_exc_i           (mem_exc_i),
        .mem_addr_i          (mem_addr_i),
        .mem_busy_i          (mem_busy_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .int_sync_o          (int_sync_o),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .redirect_ready_i    (redirect_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: int_i history, whether a sequence is in progress, whether redirect is on offer,
    // and the CP0 pulse fields visible during the current cycle.
    logic [5:0]  m_hist[$];
    bit          m_active;
    bit          m_redirect;
    logic [31:0] m_target;
    logic [31:0] m_code;
    logic [31:0] m_pc;
    bit          m_ds;
    logic [31:0] m_bad;

    task automatic model_clear();
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(6'h0);
        m_active   = 0;
        m_redirect = 0;
        m_target   = '0;
        m_code     = '0;
        m_pc       = '0;
        m_ds       = 0;
        m_bad      = '0;
    endtask

    function automatic logic [5:0] exp_sync();
        logic [5:0] s;
        s = m_hist[SYNC-1];
`ifdef EXC_CTRL_TIMER_INT_EN
        s[5] = s[5] | timer_int_i;
`endif
        return s;
    endfunction

    function automatic bit model_pend();
        logic [7:0] lines;
        lines = {exp_sync(), cause_i[9:8]} & status_i[15:8];
        return (lines != 0) && status_i[0] && !status_i[1];
    endfunction

    function automatic bit model_det();
        return mem_valid_i && (model_pend() || (mem_exc_i != 0));
    endfunction

    // Flag bits are already ordered by priority: the lowest set bit wins.
    task automatic classify(output logic [31:0] code, output logic [31:0] bad);
        logic [31:0] codes [8];
        codes = '{32'h4, 32'ha, 32'hc, 32'h8, 32'h9, 32'he, 32'h4, 32'h5};
        code = '0;
        bad  = '0;
        if (model_pend()) begin
            code = 32'h1;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (mem_exc_i[i]) begin
                    code = codes[i];
                    bad  = (i == 0) ? mem_pc_i : ((i >= 6) ? mem_addr_i : 32'h0);
                end
            end
        end
    endtask

    initial begin : compare
        logic [31:0] c;
        logic [31:0] b;
        bit          det;
        model_clear();
        forever begin
            @(negedge clk);
            if (!rst) model_clear();
            det = model_det();
            chk("int_sync",   {26'h0, int_sync_o},        {26'h0, exp_sync()});
            chk("excepttype", excepttype_o,               m_code);
            chk("inst_addr",  current_inst_addr_o,        m_pc);
            chk("delayslot",  {31'h0, is_in_delayslot_o}, {31'h0, m_ds});
            chk("bad_addr",   bad_addr_o,                 m_bad);
            chk("flush",      {31'h0, flush_o},           {31'h0, m_active || det});
            chk("rvalid",     {31'h0, redirect_valid_o},  {31'h0, m_redirect});
            chk("rpc",        redirect_pc_o,              m_redirect ? m_target : 32'h0);
            @(posedge clk);
            if (!rst) begin
                model_clear();
            end else begin
                det = model_det();
                classify(c, b);
                m_code = '0; m_pc = '0; m_ds = 0; m_bad = '0;
                if (!m_active) begin
                    if (det) begin
                        m_code     = c;
                        m_pc       = mem_pc_i;
                        m_ds       = mem_in_delayslot_i;
                        m_bad      = b;
                        m_target   = (c == 32'he) ? epc_i : VEC;
                        m_active   = 1;
                        m_redirect = !mem_busy_i;
                    end
                end else if (!m_redirect) begin
                    if (!mem_busy_i) m_redirect = 1;
                end else if (redirect_ready_i) begin
                    m_active   = 0;
                    m_redirect = 0;
                end
                m_hist.push_front(int_i);
                void'(m_hist.pop_back());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin : stim
        int r;
        probe();
        chk("rst_flush",  {31'h0, flush_o},          32'h0);
        chk("rst_rvalid", {31'h0, redirect_valid_o}, 32'h0);
        chk("rst_code",   excepttype_o,              32'h0);
        step();
        rst = 1'b1;

        // interrupt via IM2
        status_i = 32'h00000401;
        int_i    = 6'h01;
        repeat (3) step();
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'hBFC00010;
        probe();
        chk("t1_flush_det", {31'h0, flush_o}, 32'h1);
        step();
        mem_valid_i = 1'b0;
        probe();
        chk("t1_code",   excepttype_o,              32'h1);
        chk("t1_pc",     current_inst_addr_o,       32'hBFC00010);
        chk("t1_rvalid", {31'h0, redirect_valid_o}, 32'h1);
        chk("t1_rpc",    redirect_pc_o,             32'hBFC00380);
        step();
        probe();
        chk("t1_pulse_end", excepttype_o, 32'h0);
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        status_i = 32'h0;
        int_i    = 6'h0;
        probe();
        chk("t1_rvalid_drop", {31'h0, redirect_valid_o}, 32'h0);
        chk("t1_flush_drop",  {31'h0, flush_o},          32'h0);

        // ov + syscall in a delay slot
        mem_exc_i          = 8'h0C;
        mem_pc_i           = 32'h80001004;
        mem_in_delayslot_i = 1'b1;
        mem_valid_i        = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_exc_i = '0; mem_in_delayslot_i = 1'b0;
        probe();
        chk("t2_code",  excepttype_o,               32'hc);
        chk("t2_ds",    {31'h0, is_in_delayslot_o}, 32'h1);
        chk("t2_flush", {31'h0, flush_o},           32'h1);
        for (int i = 0; i < 2; i++) begin
            step();
            probe();
            chk("t2_flush_hold", {31'h0, flush_o}, 32'h1);
        end
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        probe();
        chk("t2_flush_end", {31'h0, flush_o}, 32'h0);

        // ades with bus busy
        mem_exc_i   = 8'h80;
        mem_addr_i  = 32'h80002003;
        mem_pc_i    = 32'h80003000;
        mem_busy_i  = 1'b1;
        mem_valid_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_exc_i = '0;
        probe();
        chk("t3_code",   excepttype_o,              32'h5);
        chk("t3_bad",    bad_addr_o,                32'h80002003);
        chk("t3_rvalid", {31'h0, redirect_valid_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            probe();
            chk("t3_wait", {31'h0, redirect_valid_o}, 32'h0);
        end
        mem_busy_i = 1'b0;
        step();
        probe();
        chk("t3_rvalid_up", {31'h0, redirect_valid_o}, 32'h1);
        chk("t3_rpc",       redirect_pc_o,             32'hBFC00380);
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;

        // eret to EPC with delayed accept
        mem_exc_i   = 8'h20;
        epc_i       = 32'hBFC00100;
        mem_valid_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_exc_i = '0;
        probe();
        chk("t4_code", excepttype_o,  32'he);
        chk("t4_rpc",  redirect_pc_o, 32'hBFC00100);
        for (int i = 0; i < 3; i++) begin
            step();
            probe();
            chk("t4_rpc_hold",    redirect_pc_o,             32'hBFC00100);
            chk("t4_rvalid_hold", {31'h0, redirect_valid_o}, 32'h1);
        end
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        probe();
        chk("t4_idle", {31'h0, redirect_valid_o}, 32'h0);

        // second exception during REDIRECT
        mem_exc_i   = 8'h02;
        mem_valid_i = 1'b1;
        step();
        mem_exc_i = 8'h10;
        probe();
        chk("t5_first", excepttype_o, 32'ha);
        step();
        probe();
        chk("t5_no_second", excepttype_o, 32'h0);
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0; mem_valid_i = 1'b0; mem_exc_i = '0;
        probe();
        chk("t5_no_second_b", excepttype_o,              32'h0);
        chk("t5_idle",        {31'h0, redirect_valid_o}, 32'h0);

        // reset during WAIT_MEM
        mem_exc_i   = 8'h01;
        mem_busy_i  = 1'b1;
        mem_valid_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_exc_i = '0;
        step();
        rst = 1'b0;
        #1;
        chk("t6_flush",  {31'h0, flush_o},          32'h0);
        chk("t6_rvalid", {31'h0, redirect_valid_o}, 32'h0);
        chk("t6_code",   excepttype_o,              32'h0);
        step();
        rst = 1'b1;
        mem_busy_i = 1'b0;
        probe();
        chk("t6_after", {31'h0, redirect_valid_o}, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(299) == 0) rst = 1'b0;
            r = int'($urandom_range(7));
            if (r == 4 || r == 5) mem_exc_i = 8'h01 << $urandom_range(7);
            else if (r == 6)      mem_exc_i = 8'($urandom);
            else                  mem_exc_i = '0;
            mem_valid_i        = ($urandom_range(3) != 0);
            mem_in_delayslot_i = 1'($urandom);
            mem_pc_i           = $urandom;
            mem_addr_i         = $urandom;
            epc_i              = $urandom;
            mem_busy_i         = ($urandom_range(2) == 0);
            redirect_ready_i   = 1'($urandom);
            if ($urandom_range(7) == 0) int_i = 6'($urandom);
            if ($urandom_range(15) == 0) begin
                status_i = {16'h0, 8'($urandom), 6'h0, 1'($urandom_range(3) == 0), 1'($urandom_range(3) != 0)};
                cause_i  = {22'h0, 2'($urandom), 8'h0};
            end
        end
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
